// File: rtl/online_comp_sequencer.sv
// Control sequencer for the unrolled digit-serial online arithmetic core:
// pipeline fill, triangular COMP/REST residual schedule, multi-vector jobs.
module online_comp_sequencer #(
  parameter int UNROLL = 64,
  parameter int DELAY  = 2,
  parameter int DW     = 2,
  parameter int LANES  = 1,
  parameter int AW     = 7,
  parameter int CW     = 11
) (
  input  logic                clk,
  input  logic                asyn_reset,
  input  logic                enable_comp,
  input  logic                start,
  input  logic [7:0]          n_vec,
  input  logic [CW-1:0]       iter_len,
  input  logic [LANES*DW-1:0] x_in,
  input  logic [LANES*DW-1:0] y_in,
  output logic [LANES*DW-1:0] x_value,
  output logic [LANES*DW-1:0] y_value,
  output logic                enable,
  output logic                add_enable,
  output logic                res_enable,
  output logic                finish_vec,
  output logic                done,
  output logic                busy,
  output logic [CW-1:0]       counter,
  output logic [CW-1:0]       shift_cnt,
  output logic [AW-1:0]       rest_cycle,
  output logic [AW-1:0]       rd_addr
);

  typedef enum logic [2:0] {IDLE, FILL, COMP, REST, DONE} state_t;

  localparam logic [CW-1:0] FILL_LAST = CW'(UNROLL + DELAY - 1);
  localparam logic [AW-1:0] ACC_MAX   = {AW{1'b1}};

  state_t                state_reg;
  logic [CW-1:0]         counter_reg;
  logic [AW-1:0]         accum_reg;
  logic [AW-1:0]         rest_reg;
  logic [7:0]            vec_cnt_reg;
  logic [7:0]            n_vec_reg;
  logic [CW-1:0]         iter_len_reg;
  logic [LANES*DW-1:0]   x_reg;
  logic [LANES*DW-1:0]   y_reg;

  logic                  last_rest;
  logic                  last_digit;
  logic [AW-1:0]         accum_next;

  assign last_rest  = (state_reg == REST) && (rest_reg == '0);
  assign last_digit = (counter_reg == iter_len_reg - CW'(1));
  // accum saturates so the residual read address can never wrap
  assign accum_next = (accum_reg == ACC_MAX) ? accum_reg : accum_reg + AW'(1);

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_reg    <= IDLE;
      counter_reg  <= '0;
      accum_reg    <= '0;
      rest_reg     <= '0;
      vec_cnt_reg  <= '0;
      n_vec_reg    <= '0;
      iter_len_reg <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
    end else if (enable_comp) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_vec_reg    <= (n_vec == 8'd0) ? 8'd1 : n_vec;
            iter_len_reg <= (iter_len == '0) ? CW'(1) : iter_len;
            vec_cnt_reg  <= '0;
            counter_reg  <= '0;
            state_reg    <= FILL;
          end
        end
        FILL: begin
          x_reg <= x_in;
          y_reg <= y_in;
          if (counter_reg == FILL_LAST) begin
            counter_reg <= '0;
            accum_reg   <= AW'(1);
            rest_reg    <= AW'(1);
            state_reg   <= COMP;
          end else begin
            counter_reg <= counter_reg + CW'(1);
          end
        end
        COMP: begin
          x_reg     <= x_in;
          y_reg     <= y_in;
          rest_reg  <= accum_reg - AW'(1);
          state_reg <= REST;
        end
        REST: begin
          if (rest_reg != '0) begin
            rest_reg <= rest_reg - AW'(1);
          end else if (last_digit) begin
            if (vec_cnt_reg + 8'd1 == n_vec_reg) begin
              state_reg <= DONE;
            end else begin
              vec_cnt_reg <= vec_cnt_reg + 8'd1;
              counter_reg <= '0;
              state_reg   <= FILL;
            end
          end else begin
            counter_reg <= counter_reg + CW'(1);
            accum_reg   <= accum_next;
            rest_reg    <= accum_next;
            state_reg   <= COMP;
          end
        end
        DONE: begin
          counter_reg <= '0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign res_enable = busy;
  assign enable     = (state_reg == FILL) || (state_reg == COMP);
  assign add_enable = (state_reg == COMP) || last_rest;
  assign finish_vec = enable_comp && last_rest && last_digit;
  assign done       = enable_comp && (state_reg == DONE);
  assign rd_addr    = (state_reg == REST) ? (accum_reg - rest_reg) : '0;
  assign counter    = counter_reg;
  assign rest_cycle = rest_reg;
  assign x_value    = x_reg;
  assign y_value    = y_reg;

  always_comb begin
    shift_cnt = '0;
    case (state_reg)
      FILL:       shift_cnt = FILL_LAST - counter_reg;
      COMP, REST: shift_cnt = iter_len_reg - CW'(1) - counter_reg;
      default:    shift_cnt = '0;
    endcase
  end

endmodule

// File: tb/tb_online_comp_sequencer.sv
// Scoreboard bench for online_comp_sequencer: expected per-cycle outputs are
// queued when a job is launched and popped as the DUT steps through it.
module tb_online_comp_sequencer;

  localparam int UNROLL = 4;
  localparam int DELAY  = 2;
  localparam int DW     = 2;
  localparam int LANES  = 1;
  localparam int AW     = 2;
  localparam int CW     = 11;
  localparam int F      = UNROLL + DELAY;
  localparam int AMAX   = (1 << AW) - 1;

  logic                clk = 1'b0;
  logic                asyn_reset = 1'b1;
  logic                enable_comp = 1'b0;
  logic                start = 1'b0;
  logic [7:0]          n_vec = '0;
  logic [CW-1:0]       iter_len = '0;
  logic [LANES*DW-1:0] x_in = '0;
  logic [LANES*DW-1:0] y_in = '0;
  logic [LANES*DW-1:0] x_value, y_value;
  logic                enable, add_enable, res_enable, finish_vec, done, busy;
  logic [CW-1:0]       counter, shift_cnt;
  logic [AW-1:0]       rest_cycle, rd_addr;

  online_comp_sequencer #(.UNROLL(UNROLL), .DELAY(DELAY), .DW(DW), .LANES(LANES),
                          .AW(AW), .CW(CW)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .enable_comp(enable_comp), .start(start),
    .n_vec(n_vec), .iter_len(iter_len), .x_in(x_in), .y_in(y_in),
    .x_value(x_value), .y_value(y_value), .enable(enable), .add_enable(add_enable),
    .res_enable(res_enable), .finish_vec(finish_vec), .done(done), .busy(busy),
    .counter(counter), .shift_cnt(shift_cnt), .rest_cycle(rest_cycle), .rd_addr(rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          en;
    logic          add;
    logic          res;
    logic          fin;
    logic          dn;
    logic          bsy;
    logic [AW-1:0] rd;
    logic [CW-1:0] sh;
    logic [CW-1:0] cnt;
    logic [AW-1:0] rc;
  } rec_t;

  rec_t exp_q[$];
  bit   ld_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [LANES*DW-1:0] x_exp = '0, y_exp = '0;

  // per-job observations for the scenario tasks
  int fin_n, done_n, first_fin, done_cyc, idle_cyc, max_rd;

  function automatic rec_t mk(int en, int add, int fin, int dn, int bsy,
                              int rd, int sh, int cnt, int rc);
    rec_t r;
    r.en = 1'(en); r.add = 1'(add); r.res = 1'(bsy); r.fin = 1'(fin);
    r.dn = 1'(dn); r.bsy = 1'(bsy); r.rd = AW'(rd); r.sh = CW'(sh);
    r.cnt = CW'(cnt); r.rc = AW'(rc);
    return r;
  endfunction

  function automatic rec_t sample();
    rec_t r;
    r.en = enable; r.add = add_enable; r.res = res_enable; r.fin = finish_vec;
    r.dn = done; r.bsy = busy; r.rd = rd_addr; r.sh = shift_cnt;
    r.cnt = counter; r.rc = rest_cycle;
    return r;
  endfunction

  // Expected trace of a whole job, starting the cycle after start is taken
  task automatic build(input int nv, input int il);
    int a;
    exp_q.delete();
    ld_q.delete();
    for (int v = 0; v < nv; v++) begin
      for (int c = 0; c < F; c++) begin
        exp_q.push_back(mk(1, 0, 0, 0, 1, 0, F - 1 - c, c, 0)); ld_q.push_back(1);
      end
      a = 1;
      for (int d = 0; d < il; d++) begin
        exp_q.push_back(mk(1, 1, 0, 0, 1, 0, il - 1 - d, d, a)); ld_q.push_back(1);
        for (int j = 1; j <= a; j++) begin
          exp_q.push_back(mk(0, int'(j == a), int'(j == a && d == il - 1), 0, 1,
                             j, il - 1 - d, d, a - j));
          ld_q.push_back(0);
        end
        a = (a < AMAX) ? a + 1 : AMAX;
      end
    end
    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, il - 1, 0)); ld_q.push_back(0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));      ld_q.push_back(0);
  endtask

  task automatic run_job(input int nv_in, input int il_in, input bit hold_start,
                         input int stall_at, input int stall_len, input int stop_at);
    int   idx, cyc, stall_left;
    bit   stall;
    rec_t e, act;
    build((nv_in == 0) ? 1 : nv_in, (il_in == 0) ? 1 : il_in);
    fin_n = 0; done_n = 0; first_fin = -1; done_cyc = -1; idle_cyc = -1; max_rd = 0;
    idx = 0; cyc = 0; stall_left = stall_len;
    @(negedge clk);
    enable_comp = 1'b1; start = 1'b1;
    n_vec = 8'(nv_in); iter_len = CW'(il_in);
    x_in = 2'($urandom); y_in = 2'($urandom);
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL job_idle_before_start busy=%b expected 0", busy);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      stall = (idx == stall_at) && (stall_left > 0);
      if (stall) stall_left--;
      enable_comp = !stall;
      start = hold_start && exp_q[0].bsy;
      x_in = 2'($urandom); y_in = 2'($urandom);
      n_vec = 8'($urandom); iter_len = CW'($urandom);
      #1;
      e = exp_q[0];
      if (stall) begin e.fin = 1'b0; e.dn = 1'b0; end
      act = sample();
      total_cnt++;
      if (act !== e) $display("FAIL sb_outputs idx=%0d cyc=%0d stall=%0b got=%h expected=%h",
                              idx, cyc, stall, act, e);
      else pass_cnt++;
      total_cnt++;
      if ({x_value, y_value} !== {x_exp, y_exp})
        $display("FAIL sb_xy idx=%0d cyc=%0d got=%h expected=%h", idx, cyc,
                 {x_value, y_value}, {x_exp, y_exp});
      else pass_cnt++;
      if (finish_vec === 1'b1) begin fin_n++; if (first_fin < 0) first_fin = cyc; end
      if (done === 1'b1) begin done_n++; done_cyc = cyc; end
      if (busy === 1'b0 && idle_cyc < 0) idle_cyc = cyc;
      if (int'(rd_addr) > max_rd) max_rd = int'(rd_addr);
      if (!stall) begin
        if (ld_q[0]) begin x_exp = x_in; y_exp = y_in; end
        void'(exp_q.pop_front());
        void'(ld_q.pop_front());
        idx++;
        if (idx == stop_at) break;
      end
    end
    start = 1'b0;
    enable_comp = 1'b1;
  endtask

  task automatic test_reset();
    rec_t act;
    asyn_reset = 1'b1; start = 1'b1; enable_comp = 1'b1;
    x_in = 2'b11; y_in = 2'b10;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    act = sample();
    total_cnt++;
    if (act !== '0 || x_value !== '0 || y_value !== '0)
      $display("FAIL reset_outputs got=%h x=%h y=%h expected all 0", act, x_value, y_value);
    else pass_cnt++;
    start = 1'b0; asyn_reset = 1'b0;
    x_exp = '0; y_exp = '0;
  endtask

  task automatic test_basic();
    run_job(1, 3, 1'b0, -1, 0, -1);
    total_cnt++;
    if (first_fin !== 15 || done_cyc !== 16 || idle_cyc !== 17)
      $display("FAIL basic_timing got fin=%0d done=%0d idle=%0d expected 15 16 17",
               first_fin, done_cyc, idle_cyc);
    else pass_cnt++;
    total_cnt++;
    if (fin_n !== 1 || done_n !== 1)
      $display("FAIL basic_pulses got fin=%0d done=%0d expected 1 1", fin_n, done_n);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    run_job(1, 6, 1'b0, -1, 0, -1);
    total_cnt++;
    if (max_rd !== AMAX) $display("FAIL sat_max_rd got=%0d expected %0d", max_rd, AMAX);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc !== F + 21 + 1) $display("FAIL sat_length got done=%0d expected %0d",
                                          done_cyc, F + 22);
    else pass_cnt++;
  endtask

  task automatic test_multi_vec();
    run_job(2, 2, 1'b0, -1, 0, -1);
    total_cnt++;
    if (fin_n !== 2 || done_n !== 1)
      $display("FAIL multi_pulses got fin=%0d done=%0d expected 2 1", fin_n, done_n);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc !== 23) $display("FAIL multi_length got done=%0d expected 23", done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    run_job(1, 3, 1'b0, 9, 5, -1);
    total_cnt++;
    if (done_cyc !== 21 || fin_n !== 1)
      $display("FAIL stall_rest got done=%0d fin=%0d expected 21 1", done_cyc, fin_n);
    else pass_cnt++;
    run_job(1, 3, 1'b0, 14, 5, -1);
    total_cnt++;
    if (first_fin !== 20 || fin_n !== 1)
      $display("FAIL stall_final got fin_cyc=%0d fin=%0d expected 20 1", first_fin, fin_n);
    else pass_cnt++;
    run_job(1, 3, 1'b0, 15, 5, -1);
    total_cnt++;
    if (done_cyc !== 21 || done_n !== 1)
      $display("FAIL stall_done got done=%0d n=%0d expected 21 1", done_cyc, done_n);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    rec_t act;
    int   seen_done;
    run_job(1, 3, 1'b0, -1, 0, F);
    @(negedge clk); #1;
    total_cnt++;
    if (enable !== 1'b1 || add_enable !== 1'b1)
      $display("FAIL abort_in_comp got en=%b add=%b expected 1 1", enable, add_enable);
    else pass_cnt++;
    asyn_reset = 1'b1;
    #1;
    act = sample();
    total_cnt++;
    if (act !== '0 || x_value !== '0 || y_value !== '0)
      $display("FAIL abort_outputs got=%h x=%h y=%h expected all 0", act, x_value, y_value);
    else pass_cnt++;
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    asyn_reset = 1'b0;
    x_exp = '0; y_exp = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    total_cnt++;
    if (seen_done !== 0) $display("FAIL abort_no_done got %0d active cycles expected 0",
                                  seen_done);
    else pass_cnt++;
    run_job(1, 3, 1'b0, -1, 0, -1);
    total_cnt++;
    if (done_n !== 1 || done_cyc !== 16)
      $display("FAIL abort_rerun got done=%0d at %0d expected 1 at 16", done_n, done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    run_job(0, 0, 1'b1, -1, 0, -1);
    total_cnt++;
    if (first_fin !== F + 2 || done_cyc !== F + 3 || idle_cyc !== F + 4)
      $display("FAIL held_timing got fin=%0d done=%0d idle=%0d expected %0d %0d %0d",
               first_fin, done_cyc, idle_cyc, F + 2, F + 3, F + 4);
    else pass_cnt++;
    total_cnt++;
    if (fin_n !== 1 || done_n !== 1)
      $display("FAIL held_pulses got fin=%0d done=%0d expected 1 1", fin_n, done_n);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL held_no_restart got busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_multi_vec();
    test_stall();
    test_abort();
    test_start_held();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
